// File: rtl/func_issuer.sv
// func_issuer: queues 8-bit operand pairs, issues them one at a time to the
// `func` stage (start/busy handshake) and returns each 5-bit result in order.
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   in_valid_i/in_ready_o   operand handshake, a_bi/b_bi operands
//   f_start_o, f_a_bo/f_b_bo  start pulse and held operands to `func`
//   f_busy_i, f_y_bi        `func` busy flag and result
//   y_valid_o/y_ready_i     result handshake, y_bo result
//   pending_o               FIFO occupancy 0..DEPTH
//   err_o                   sticky watchdog error
module func_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [7:0]               a_bi,
    input  logic [7:0]               b_bi,
    output logic                     f_start_o,
    output logic [7:0]               f_a_bo,
    output logic [7:0]               f_b_bo,
    input  logic [1:0]               f_busy_i,
    input  logic [4:0]               f_y_bi,
    output logic                     y_valid_o,
    input  logic                     y_ready_i,
    output logic [4:0]               y_bo,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t          state;
    logic [7:0]      mem_a [DEPTH];
    logic [7:0]      mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      wd;
    logic            push;
    logic            pop;
    logic            y_fire;

    // Ready depends only on registered occupancy, so a same-cycle pop
    // never opens a slot for a push while full.
    assign in_ready_o = (pending_o != CW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state == IDLE) && (pending_o != '0) && !y_valid_o;
    assign y_fire     = y_valid_o && y_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a[wr_ptr] <= a_bi;
            mem_b[wr_ptr] <= b_bi;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pending_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                pending_o <= pending_o + CW'(1);
            else if (pop && !push)
                pending_o <= pending_o - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            f_start_o <= 1'b0;
            f_a_bo    <= '0;
            f_b_bo    <= '0;
            y_valid_o <= 1'b0;
            y_bo      <= '0;
            err_o     <= 1'b0;
            wd        <= '0;
        end else begin
            if (y_fire) y_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        f_a_bo    <= mem_a[rd_ptr];
                        f_b_bo    <= mem_b[rd_ptr];
                        f_start_o <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    f_start_o <= 1'b0;
                    wd        <= '0;
                    state     <= GUARD;
                end
                // func registers start, so busy is not yet meaningful here
                GUARD: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (f_busy_i == 2'b00) begin
                        y_bo      <= f_y_bi;
                        y_valid_o <= 1'b1;
                        state     <= IDLE;
                    end else if (wd == 8'(TIMEOUT - 1)) begin
                        err_o     <= 1'b1;
                        y_bo      <= '0;
                        y_valid_o <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                HOLD: begin
                    if (y_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_func_issuer.sv
// tb_func_issuer: directed bench for func_issuer with a behavioural
// `func` model (4-cycle compute, optional stuck-busy mode).
module tb_func_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       f_start;
    logic [7:0] f_a;
    logic [7:0] f_b;
    logic [1:0] f_busy;
    logic [4:0] f_y;
    logic       y_valid;
    logic       y_ready;
    logic [4:0] y;
    logic [2:0] pending;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    int         starts = 0;
    logic [4:0] got[$];
    logic       stuck = 1'b0;
    int         fcnt;
    int         peak;
    bit         stall;

    always #5 clk = ~clk;

    func_issuer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_bi       (a),
        .b_bi       (b),
        .f_start_o  (f_start),
        .f_a_bo     (f_a),
        .f_b_bo     (f_b),
        .f_busy_i   (f_busy),
        .f_y_bi     (f_y),
        .y_valid_o  (y_valid),
        .y_ready_i  (y_ready),
        .y_bo       (y),
        .pending_o  (pending),
        .err_o      (err)
    );

    function automatic logic [4:0] fmodel(input logic [7:0] pa, input logic [7:0] pb);
        int c = 0;
        int s = 0;
        while ((c + 1) * (c + 1) * (c + 1) <= int'(pb)) c++;
        while ((s + 1) * (s + 1) <= int'(pa) + c) s++;
        return 5'(s);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_busy <= 2'b00;
            f_y    <= 5'd0;
            fcnt   <= 0;
        end else if (f_start) begin
            f_busy <= stuck ? 2'b01 : 2'b10;
            fcnt   <= 4;
        end else if (f_busy != 2'b00 && !stuck) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) begin
                f_busy <= 2'b00;
                f_y    <= fmodel(f_a, f_b);
            end
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b1 && f_start === 1'b1) starts++;
        if (rst === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) got.push_back(y);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        a = 8'd0;
        b = 8'd0;
        y_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic push(input logic [7:0] pa, input logic [7:0] pb);
        int n = 0;
        in_valid = 1'b1;
        a = pa;
        b = pb;
        while (!in_ready && n < 100) begin
            stall = 1'b1;
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout in_ready got %0b required 1", in_ready);
        end
        step();
        if (int'(pending) > peak) peak = int'(pending);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
            if (int'(pending) > peak) peak = int'(pending);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        y_ready = 1'b0;
        step();
        checks++; if (f_start !== 1'b0) begin errors++; $display("FAIL rst_f_start got %0b required 0", f_start); end
        checks++; if (f_a !== 8'd0) begin errors++; $display("FAIL rst_f_a got %0d required 0", f_a); end
        checks++; if (f_b !== 8'd0) begin errors++; $display("FAIL rst_f_b got %0d required 0", f_b); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %0b required 0", y_valid); end
        checks++; if (y !== 5'd0) begin errors++; $display("FAIL rst_y got %0d required 0", y); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rst_pending got %0d required 0", pending); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b required 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b required 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int bg = got.size();
        int bs = starts;
        y_ready = 1'b1;
        push(8'd45, 8'd64);
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending1 got %0d required 1", pending); end
        wait_results(bg + 1, 40);
        step();
        checks++;
        if (got.size() != bg + 1) begin
            errors++;
            $display("FAIL single_count got %0d required %0d", got.size() - bg, 1);
        end else if (got[bg] !== 5'd7) begin
            errors++;
            $display("FAIL single_y got %0d required 7", got[bg]);
        end
        checks++; if (starts - bs != 1) begin errors++; $display("FAIL single_starts got %0d required 1", starts - bs); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending0 got %0d required 0", pending); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL single_y_valid got %0b required 0", y_valid); end
    endtask

    task automatic test_burst();
        logic [4:0] exp_y[4] = '{5'd0, 5'd1, 5'd3, 5'd11};
        int bg = got.size();
        peak = 0;
        stall = 1'b0;
        y_ready = 1'b1;
        push(8'd0, 8'd0);
        push(8'd1, 8'd1);
        push(8'd12, 8'd60);
        push(8'd123, 8'd223);
        wait_results(bg + 4, 120);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL burst_stall got %0b required 0", stall); end
        checks++; if (peak != 3) begin errors++; $display("FAIL burst_peak got %0d required 3", peak); end
        checks++;
        if (got.size() != bg + 4) begin
            errors++;
            $display("FAIL burst_count got %0d required 4", got.size() - bg);
        end
        for (int i = 0; i < 4; i++) begin
            if (got.size() > bg + i) begin
                checks++;
                if (got[bg + i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL burst_y%0d got %0d required %0d", i, got[bg + i], exp_y[i]);
                end
            end
        end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL burst_pending got %0d required 0", pending); end
    endtask

    task automatic test_full_and_contention();
        logic [4:0] exp_y[6] = '{5'd16, 5'd16, 5'd6, 5'd2, 5'd16, 5'd7};
        int bg = got.size();
        int bs = starts;
        int k = 0;
        y_ready = 1'b0;
        push(8'd255, 8'd255);
        push(8'd255, 8'd30);
        push(8'd30, 8'd255);
        push(8'd1, 8'd255);
        push(8'd255, 8'd1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b required 0", in_ready); end
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pending got %0d required 4", pending); end
        while (y_valid !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        repeat (5) step();
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL hold_y_valid got %0b required 1", y_valid); end
        checks++; if (y !== 5'd16) begin errors++; $display("FAIL hold_y got %0d required 16", y); end
        checks++; if (starts - bs != 1) begin errors++; $display("FAIL hold_starts got %0d required 1", starts - bs); end
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL hold_pending got %0d required 4", pending); end
        y_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'd45;
        b = 8'd64;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL contend_in_ready0 got %0b required 0", in_ready); end
        step();
        checks++; if (pending !== 3'd3) begin errors++; $display("FAIL contend_pending3 got %0d required 3", pending); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL contend_in_ready1 got %0b required 1", in_ready); end
        step();
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL contend_pending4 got %0d required 4", pending); end
        in_valid = 1'b0;
        wait_results(bg + 6, 200);
        repeat (10) step();
        checks++;
        if (got.size() != bg + 6) begin
            errors++;
            $display("FAIL full_count got %0d required 6", got.size() - bg);
        end
        for (int i = 0; i < 6; i++) begin
            if (got.size() > bg + i) begin
                checks++;
                if (got[bg + i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL full_y%0d got %0d required %0d", i, got[bg + i], exp_y[i]);
                end
            end
        end
        checks++; if (starts - bs != 6) begin errors++; $display("FAIL full_starts got %0d required 6", starts - bs); end
    endtask

    task automatic test_timeout();
        int n = -1;
        int k = 0;
        int bs;
        do_reset();
        bs = starts;
        stuck = 1'b1;
        y_ready = 1'b0;
        push(8'd9, 8'd9);
        while (err !== 1'b1 && k < 60) begin
            step();
            k++;
            if (f_start === 1'b1) n = 0;
            else if (n >= 0) n++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL wd_latency got %0d required 10", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err got %0b required 1", err); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL wd_y_valid got %0b required 1", y_valid); end
        checks++; if (y !== 5'd0) begin errors++; $display("FAIL wd_y got %0d required 0", y); end
        y_ready = 1'b1;
        step();
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL wd_drain got %0b required 0", y_valid); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %0b required 1", err); end
        checks++; if (starts - bs != 1) begin errors++; $display("FAIL wd_starts got %0d required 1", starts - bs); end
        stuck = 1'b0;
        do_reset();
    endtask

    task automatic test_async_reset();
        int bs;
        do_reset();
        y_ready = 1'b0;
        push(8'd45, 8'd64);
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        push(8'd5, 8'd6);
        checks++; if (pending !== 3'd3) begin errors++; $display("FAIL ar_pre_pending got %0d required 3", pending); end
        checks++; if (f_a !== 8'd45) begin errors++; $display("FAIL ar_pre_f_a got %0d required 45", f_a); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL ar_pending got %0d required 0", pending); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got %0b required 1", in_ready); end
        checks++; if (f_a !== 8'd0) begin errors++; $display("FAIL ar_f_a got %0d required 0", f_a); end
        checks++; if (f_b !== 8'd0) begin errors++; $display("FAIL ar_f_b got %0d required 0", f_b); end
        checks++; if (f_start !== 1'b0) begin errors++; $display("FAIL ar_f_start got %0b required 0", f_start); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL ar_y_valid got %0b required 0", y_valid); end
        step();
        rst = 1'b1;
        bs = starts;
        repeat (20) step();
        checks++; if (starts != bs) begin errors++; $display("FAIL ar_starts got %0d required %0d", starts, bs); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL ar_post_pending got %0d required 0", pending); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL ar_post_y_valid got %0b required 0", y_valid); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        a = 8'd0;
        b = 8'd0;
        y_ready = 1'b0;
        peak = 0;
        stall = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_full_and_contention();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
